// File: rtl/scan_pkg.sv
// ============================================================================
//  Module      : scan_pkg
//  Description : Shared types and defaults for the scan-chain controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package scan_pkg;

    localparam int CHAIN_LEN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_IN  = 2'd1,
        CAPTURE   = 2'd2,
        SHIFT_OUT = 2'd3
    } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/scan_bit_counter.sv
// ============================================================================
//  Module      : scan_bit_counter
//  Description : Shift bit counter with clear; wraps to 0 after CHAIN_LEN-1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_bit_counter #(
    parameter  int CHAIN_LEN = 8,
    localparam int W         = $clog2(CHAIN_LEN)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    localparam logic [W-1:0] c_last = W'(CHAIN_LEN - 1);

    assign o_tc = (o_count == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= '0;
        end else if (i_en) begin
            o_count <= o_tc ? '0 : o_count + W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/scan_ctrl.sv
// ============================================================================
//  Module      : scan_ctrl
//  Description : Shifts a pattern into a scan chain, optionally captures once,
//                and shifts the chain contents back out into Result.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Capture,
    input  logic [CHAIN_LEN-1:0] Pattern,
    input  logic                 SDO,
    output logic                 Test,
    output logic                 SDI,
    output logic                 Load,
    output logic                 Busy,
    output logic                 Done,
    output logic [CHAIN_LEN-1:0] Result
);

    localparam int            W      = $clog2(CHAIN_LEN);
    localparam logic [W-1:0]  c_last = W'(CHAIN_LEN - 1);

    scan_state_t          r_state;
    scan_state_t          w_state_nxt;
    logic [W-1:0]         w_cnt;
    logic                 w_tc;
    logic [CHAIN_LEN-1:0] r_pat;
    logic                 r_cap;
    logic                 w_test_nxt;
    logic                 w_load_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    scan_bit_counter #(
        .CHAIN_LEN (CHAIN_LEN)
    ) u_cnt (
        .clk     (Clock),
        .rst     (Reset),
        .i_clr   (r_state == IDLE),
        .i_en    ((r_state == SHIFT_IN) || (r_state == SHIFT_OUT)),
        .o_count (w_cnt),
        .o_tc    (w_tc)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            Test    <= 1'b0;
            Load    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            Test    <= w_test_nxt;
            Load    <= w_load_nxt;
            Busy    <= w_busy_nxt;
            Done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (Start) w_state_nxt = SHIFT_IN;
            SHIFT_IN:  if (w_tc)  w_state_nxt = r_cap ? CAPTURE : SHIFT_OUT;
            CAPTURE:              w_state_nxt = SHIFT_OUT;
            SHIFT_OUT: if (w_tc)  w_state_nxt = IDLE;
            default:              w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        w_test_nxt = 1'b0;
        w_load_nxt = 1'b0;
        w_busy_nxt = 1'b0;
        case (w_state_nxt)
            SHIFT_IN, SHIFT_OUT: begin
                w_test_nxt = 1'b1;
                w_busy_nxt = 1'b1;
            end
            CAPTURE: begin
                w_load_nxt = 1'b1;
                w_busy_nxt = 1'b1;
            end
            default: ;
        endcase
        w_done_nxt = (r_state == SHIFT_OUT) && w_tc;
    end

    // The pattern shifts out MSB first with zero fill, so SDI returns to 0
    // on its own once the last bit has left.
    assign SDI = r_pat[CHAIN_LEN-1];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_pat  <= '0;
            r_cap  <= 1'b0;
            Result <= '0;
        end else begin
            if ((r_state == IDLE) && Start) begin
                r_pat <= Pattern;
                r_cap <= Capture;
            end else if (r_state == SHIFT_IN) begin
                r_pat <= r_pat << 1;
            end
            if (r_state == SHIFT_OUT) begin
                Result[c_last - w_cnt] <= SDO;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scan_ctrl.sv
// ============================================================================
//  Module      : tb_scan_ctrl
//  Description : Self-checking bench for scan_ctrl driving modelled scan chains.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, capture = 1'b0;
    logic [7:0] pattern = '0, chain_d = '0, result;
    logic       sdo, test, sdi, load, busy, done;
    logic [7:0] chain_q;

    logic       start2 = 1'b0;
    logic [1:0] pattern2 = '0, result2;
    logic       sdo2, test2, sdi2, load2, busy2, done2;
    logic [1:0] chain2_q;

    int n_tests = 0, n_fail = 0, done_cnt = 0;
    logic [7:0] exp_q[$];
    logic [1:0] exp2_q[$];

    always #5 clk = ~clk;

    scan_ctrl #(.CHAIN_LEN(8)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .Capture(capture), .Pattern(pattern),
        .SDO(sdo), .Test(test), .SDI(sdi), .Load(load), .Busy(busy), .Done(done), .Result(result)
    );

    scan_ctrl #(.CHAIN_LEN(2)) dut2 (
        .Clock(clk), .Reset(rst), .Start(start2), .Capture(1'b0), .Pattern(pattern2),
        .SDO(sdo2), .Test(test2), .SDI(sdi2), .Load(load2), .Busy(busy2), .Done(done2), .Result(result2)
    );

    // scanreg cells: async active-low reset, scan has priority over load
    for (genvar k = 0; k < 8; k++) begin : g_chain
        always_ff @(posedge clk or negedge (~rst)) begin
            if (rst)       chain_q[k] <= 1'b0;
            else if (test) chain_q[k] <= (k == 0) ? sdi : chain_q[(k == 0) ? 0 : k-1];
            else if (load) chain_q[k] <= chain_d[k];
        end
    end
    assign sdo = chain_q[7];

    for (genvar k = 0; k < 2; k++) begin : g_chain2
        always_ff @(posedge clk or negedge (~rst)) begin
            if (rst)        chain2_q[k] <= 1'b0;
            else if (test2) chain2_q[k] <= (k == 0) ? sdi2 : chain2_q[0];
            else if (load2) chain2_q[k] <= 1'b0;
        end
    end
    assign sdo2 = chain2_q[1];

    always @(posedge clk) if (done) done_cnt++;

    task automatic start_op(input logic [7:0] p, input logic cap);
        start = 1'b1; pattern = p; capture = cap;
        exp_q.push_back(cap ? chain_d : p);
        @(negedge clk);
        start = 1'b0; pattern = ~p; capture = ~cap;
    endtask

    // Waits for Done; e = number of edges after the Start edge.
    task automatic wait_done(input int inject_at, output int e, output int loads, output int load_at);
        e = 0; loads = 0; load_at = -1;
        while (!done && e < 100) begin
            if (e == inject_at) begin start = 1'b1; pattern = 8'h00; end
            else start = 1'b0;
            @(negedge clk); e++;
            if (load) begin loads++; if (load_at < 0) load_at = e; end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        n_tests++;
        if ({test, sdi, load, busy, done, result} !== 13'd0) begin
            n_fail++; $display("FAIL reset_hold: got %b required 0", {test, sdi, load, busy, done, result});
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({test, sdi, load, busy, done, result, test2, sdi2, load2, busy2, done2, result2} !== 20'd0) begin
            n_fail++; $display("FAIL reset_release: got %b required 0",
                {test, sdi, load, busy, done, result, test2, sdi2, load2, busy2, done2, result2});
        end
    endtask

    task automatic test_basic;
        int e, loads, load_at;
        logic [7:0] exp;
        start_op(8'hA5, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || test !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy_rise: got busy=%b test=%b required 1 1", busy, test);
        end
        wait_done(-1, e, loads, load_at);
        exp = exp_q.pop_front();
        n_tests++;
        if (e !== 16) begin n_fail++; $display("FAIL basic_latency: got %0d required 16", e); end
        n_tests++;
        if (result !== exp) begin n_fail++; $display("FAIL basic_result: got %h required %h", result, exp); end
        n_tests++;
        if (chain_q !== 8'h00 || busy !== 1'b0 || loads !== 0) begin
            n_fail++; $display("FAIL basic_end: got chain=%h busy=%b loads=%0d required 00 0 0", chain_q, busy, loads);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || result !== exp) begin
            n_fail++; $display("FAIL basic_hold: got done=%b result=%h required 0 %h", done, result, exp);
        end
    endtask

    task automatic test_capture;
        int e, loads, load_at;
        logic [7:0] exp;
        chain_d = 8'h3C;
        start_op(8'hFF, 1'b1);
        wait_done(-1, e, loads, load_at);
        exp = exp_q.pop_front();
        n_tests++;
        if (loads !== 1 || load_at !== 8) begin
            n_fail++; $display("FAIL capture_load: got cycles=%0d at=%0d required 1 at 8", loads, load_at);
        end
        n_tests++;
        if (e !== 17) begin n_fail++; $display("FAIL capture_latency: got %0d required 17", e); end
        n_tests++;
        if (result !== exp) begin n_fail++; $display("FAIL capture_result: got %h required %h", result, exp); end
        chain_d = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_ignore_start;
        int e, loads, load_at, d0;
        logic [7:0] exp;
        d0 = done_cnt;
        start_op(8'hC3, 1'b0);
        wait_done(5, e, loads, load_at);
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp || e !== 16) begin
            n_fail++; $display("FAIL ignore_result: got %h after %0d required %h after 16", result, e, exp);
        end
        repeat (25) @(negedge clk);
        n_tests++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0 || result !== exp) begin
            n_fail++; $display("FAIL ignore_single_done: got dones=%0d busy=%b result=%h required 1 0 %h",
                done_cnt - d0, busy, result, exp);
        end
    endtask

    task automatic test_reset_mid;
        int e, loads, load_at, d0;
        logic [7:0] exp;
        start = 1'b1; pattern = 8'h3F; capture = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({test, sdi, load, busy, done, result} !== 13'd0) begin
            n_fail++; $display("FAIL midreset_outputs: got %b required 0", {test, sdi, load, busy, done, result});
        end
        d0 = done_cnt;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_tests++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midreset_no_done: got dones=%0d busy=%b required 0 0", done_cnt - d0, busy);
        end
        start_op(8'h81, 1'b0);
        wait_done(-1, e, loads, load_at);
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp || e !== 16) begin
            n_fail++; $display("FAIL midreset_next_op: got %h after %0d required %h after 16", result, e, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int e, loads, load_at;
        logic [7:0] exp;
        start_op(8'h24, 1'b0);
        wait_done(-1, e, loads, load_at);
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp) begin n_fail++; $display("FAIL b2b_first: got %h required %h", result, exp); end
        start_op(8'h5A, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept: got busy=%b done=%b required 1 0", busy, done);
        end
        wait_done(-1, e, loads, load_at);
        exp = exp_q.pop_front();
        n_tests++;
        if (result !== exp || e !== 16) begin
            n_fail++; $display("FAIL b2b_second: got %h after %0d required %h after 16", result, e, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_len2;
        int e;
        logic [1:0] exp;
        start2 = 1'b1; pattern2 = 2'b10;
        exp2_q.push_back(2'b10);
        @(negedge clk);
        start2 = 1'b0; pattern2 = 2'b01;
        e = 0;
        while (!done2 && e < 50) begin @(negedge clk); e++; end
        exp = exp2_q.pop_front();
        n_tests++;
        if (result2 !== exp || e !== 4) begin
            n_fail++; $display("FAIL len2_result: got %b after %0d required %b after 4", result2, e, exp);
        end
        n_tests++;
        if (chain2_q !== 2'b00 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL len2_end: got chain=%b busy=%b required 00 0", chain2_q, busy2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_capture();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_len2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
